// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, shifter modes and flag bundle
// shared by the alu_pipe slice.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_NAND  = 4'h6;
  localparam logic [3:0] OP_NOR   = 4'h7;
  localparam logic [3:0] OP_ADC   = 4'h8;
  localparam logic [3:0] OP_SBB   = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_ASR   = 4'hC;
  localparam logic [3:0] OP_ROL   = 4'hD;
  localparam logic [3:0] OP_ROR   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  localparam logic [2:0] SH_SHL = 3'd0;
  localparam logic [2:0] SH_SHR = 3'd1;
  localparam logic [2:0] SH_ASR = 3'd2;
  localparam logic [2:0] SH_ROL = 3'd3;
  localparam logic [2:0] SH_ROR = 3'd4;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: op/operand request and registered
// result/flags response with valid/ready on each side.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             use_acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, op, use_acc, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  zero, carry, negative, overflow
  );

  modport slave (
    input  in_valid, op, use_acc, a, b, out_ready,
    output in_ready, out_valid, result,
    output zero, carry, negative, overflow
  );

endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shift/rotate,
// returns {carry_out, result}.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_amt,
  output logic [WIDTH:0]   o_out
);

  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH:0]     w_asr;
  logic [2*WIDTH-1:0] w_rol;
  logic [2*WIDTH-1:0] w_ror;
  logic               w_nz;

  // Guard bit beside the data catches the last bit out
  assign w_shl = {1'b0, i_data} << i_amt;
  assign w_shr = {i_data, 1'b0} >> i_amt;
  assign w_asr = $signed({i_data, 1'b0}) >>> i_amt;
  assign w_rol = {i_data, i_data} << i_amt;
  assign w_ror = {i_data, i_data} >> i_amt;
  assign w_nz  = |i_amt;

  always_comb begin
    o_out = '0;
    unique case (i_mode)
      SH_SHL: o_out = w_shl;
      SH_SHR: o_out = {w_shr[0], w_shr[WIDTH:1]};
      SH_ASR: o_out = {w_asr[0], w_asr[WIDTH:1]};
      SH_ROL: o_out = {w_nz & w_rol[WIDTH],
                       w_rol[2*WIDTH-1:WIDTH]};
      SH_ROR: o_out = {w_nz & w_ror[WIDTH-1],
                       w_ror[WIDTH-1:0]};
      default: o_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-generic ALU with one output register,
// persistent carry and accumulator operand mode.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_pipe_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] r_result;
  alu_flags_t       r_flags;
  logic             r_valid;

  logic [WIDTH-1:0] w_effa;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_sh;
  logic [3:0]       w_shop;
  logic             w_cin;
  logic             w_bin;
  logic             w_accept;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  alu_flags_t       w_flags;

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  assign w_effa = bus.use_acc ? r_result : bus.a;
  assign w_cin  = (bus.op == OP_ADC) && r_flags.carry;
  assign w_bin  = (bus.op == OP_SBB) && r_flags.carry;
  assign w_add  = {1'b0, w_effa} + {1'b0, bus.b}
                + {{WIDTH{1'b0}}, w_cin};
  assign w_sub  = {1'b0, w_effa} - {1'b0, bus.b}
                - {{WIDTH{1'b0}}, w_bin};
  assign w_shop = bus.op - OP_SHL;

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .i_mode (w_shop[2:0]),
    .i_data (w_effa),
    .i_amt  (bus.b[SHW-1:0]),
    .o_out  (w_sh)
  );

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (bus.op)
      OP_ADD, OP_ADC: begin
        w_res = w_add[MSB:0];
        w_c   = w_add[WIDTH];
        w_v   = (w_effa[MSB] == bus.b[MSB])
             && (w_add[MSB] != w_effa[MSB]);
      end
      OP_SUB, OP_SBB: begin
        w_res = w_sub[MSB:0];
        w_c   = w_sub[WIDTH];
        w_v   = (w_effa[MSB] != bus.b[MSB])
             && (w_sub[MSB] != w_effa[MSB]);
      end
      OP_AND:  w_res = w_effa & bus.b;
      OP_OR:   w_res = w_effa | bus.b;
      OP_XOR:  w_res = w_effa ^ bus.b;
      OP_NOT:  w_res = ~w_effa;
      OP_NAND: w_res = ~(w_effa & bus.b);
      OP_NOR:  w_res = ~(w_effa | bus.b);
      OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR:
        {w_c, w_res} = w_sh;
      default: w_res = bus.b;
    endcase
  end

  always_comb begin
    w_flags          = '0;
    w_flags.zero     = (w_res == '0);
    w_flags.carry    = w_c;
    w_flags.negative = w_res[MSB];
    w_flags.overflow = w_v;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
      r_valid  <= 1'b0;
    end else if (w_accept) begin
      r_result <= w_res;
      r_flags  <= w_flags;
      r_valid  <= 1'b1;
    end else if (bus.out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_flags.zero;
  assign bus.carry     = r_flags.carry;
  assign bus.negative  = r_flags.negative;
  assign bus.overflow  = r_flags.overflow;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. Adds:
- WIDTH-generic datapath with a one-stage output register and valid/ready handshake.
- Persistent carry flag for multi-word ADC/SBB chains.
- Accumulator operand mode and barrel shifts/rotates.

It sits between an instruction sequencer (upstream) and a writeback or consumer stage (downstream).

Parameters:
WIDTH, 8, datapath width in bits (>=4, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk        input   1       system clock, rising edge
rst_n      input   1       synchronous active-low reset
in_valid   input   1       op/operands valid
in_ready   output  1       block can accept this cycle
op         input   4       opcode
use_acc    input   1       1: operand A := current result register (accumulator)
a          input   WIDTH   operand A
b          input   WIDTH   operand B; shift amount = b[SHW-1:0]
out_valid  output  1       result/flags valid
out_ready  input   1       downstream accepts
result     output  WIDTH   registered result
zero       output  1       result == 0
carry      output  1       carry/borrow flag; also the ADC/SBB carry-in
negative   output  1       result[WIDTH-1]
overflow   output  1       signed overflow

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous, active-low, and sampled only on the rising edge of clk.
  - Reset values: result=0, zero=0, carry=0, negative=0, overflow=0, out_valid=0.
  - Reset wins over any simultaneous transfer, including a stalled out_valid=1 (that result is dropped).
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept, result and flags load next edge and out_valid=1. Latency is 1 cycle, throughput 1/cycle.
  - If out_valid && out_ready && !accept, then out_valid=0 next edge. Result and flags hold their values.
  - While out_valid && !out_ready, result and flags are frozen.
- Operand A: effA = use_acc ? result (current register value, even if already consumed) : a.
- Opcodes (carry/overflow shown per op):
  - 0 ADD: effA+b. carry=bit WIDTH of sum. V=signed overflow.
  - 1 SUB: effA-b. carry=borrow (1 iff effA<b unsigned). V=signed.
  - 2 AND, 3 OR, 4 XOR, 5 NOT(~effA), 6 NAND, 7 NOR: carry=0, V=0.
  - 8 ADC: effA+b+carry. Flags as ADD.
  - 9 SBB: effA-b-carry. carry=borrow. V=signed.
  - A SHL, B SHR (logical), C ASR (arithmetic):
    - carry = last bit shifted out.
    - Amount 0 gives result=effA, carry=0. V=0.
  - D ROL, E ROR:
    - carry = last bit rotated through (ROL: new result[0], ROR: new result[WIDTH-1]).
    - Amount 0 gives carry=0. V=0.
  - F PASSB: result=b, carry=0, V=0.
- Flags:
  - zero and negative are derived from the new result.
  - All flags update only on accept, with the same edge as result.
- Carry chaining:
  - ADC/SBB use the carry register value at the accept cycle, i.e. from the previous accepted op.
  - This holds back-to-back: accepting the next op in the same cycle the previous result drains is legal.

Decomposition:
- Package alu_pkg: localparam opcodes OP_ADD..OP_PASSB (4-bit), typedef alu_flags_t {zero, carry, negative, overflow}.
- Sub-module alu_shifter: combinational barrel shift/rotate (WIDTH, SHW, mode[2:0]) returning {carry_out, result}.
- Adder/logic and the output register stay in alu_pipe.

Test Plan (WIDTH=8):
- ADD a=0xFF b=0x01, out_ready=1 -> next cycle out_valid=1, result=0x00, zero=1, carry=1, overflow=0, negative=0.
- 16-bit add: ADD 0xFF+0x01 then back-to-back ADC 0x01+0x00 -> results 0x00 (carry=1), then 0x02 (carry=0).
- SUB 0x80-0x01 -> 0x7F, carry=0, overflow=1. SUB 0x01-0x02 -> 0xFF, carry=1, negative=1. SBB 0x05-0x01 with carry=1 -> 0x03.
- Shifts:
  - ROR 0x81 by 1 -> 0xC0, carry=1.
  - ASR 0x80 by 3 -> 0xF0, carry=0.
  - SHL 0x81 by 1 -> 0x02, carry=1.
  - SHL 0x5A by 0 -> 0x5A, carry=0.
- Backpressure with PASSB 0x11 then ADD:
  - Hold out_ready=0 3 cycles -> in_ready=0, result stays 0x11, new op not consumed.
  - Raise out_ready -> that op accepted same cycle, new result next cycle.
- Accumulator, then reset mid-stall:
  - PASSB 0x10, then ADD use_acc=1 b=0x05 -> 0x15.
  - rst_n=0 for one edge while out_valid=1 and stalled -> out_valid=0, result=0x00, all flags 0.
